// File: rtl/bus_event_fifo.sv
// Hardware-to-CPU event mailbox: hardware pushes words into a FIFO and the CPU
// pops them (DATA) or inspects/controls the queue (STAT) over the word bus.
module bus_event_fifo #(
  parameter logic [31:0] _ADD   = 32'h0,
  parameter int          _BYTE  = 4,
  parameter int          _DEPTH = 8
) (
  input  logic              io_clk,
  input  logic              io_rst,
  input  logic              hw_valid,
  input  logic [_BYTE*8-1:0] hw_data,
  input  logic              io_ren,
  input  logic [3:0]        io_wen,
  input  logic [31:0]       io_addr,
  input  logic [31:0]       io_din,
  output logic [31:0]       io_rdata,
  output logic              io_rvalid,
  output logic              io_irq
);
  localparam int AW = $clog2(_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = _BYTE * 8;

  logic [WW-1:0] mem_q [_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic        hit, data_rd, stat_rd, stat_wr, flush;
  logic        empty, full, pop, push_ok, ovf_set, udf_set;
  logic        ovf_clr, udf_clr;
  logic [31:0] head_ext, stat_word;

  // Bits of the bus that no register field decodes.
  logic unused_bus;
  assign unused_bus = ^{io_din[30:18], io_din[15:0], io_wen[1:0], io_addr[1:0]};

  always_comb begin
    hit     = (io_addr[31:3] == _ADD[31:3]);
    data_rd = io_ren & hit & ~io_addr[2];
    stat_rd = io_ren & hit & io_addr[2];
    stat_wr = hit & io_addr[2];
    flush   = stat_wr & io_wen[3] & io_din[31];
    ovf_clr = stat_wr & io_wen[2] & io_din[16];
    udf_clr = stat_wr & io_wen[2] & io_din[17];

    empty   = (count_q == '0);
    full    = (count_q == CW'(_DEPTH));
    pop     = data_rd & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok = hw_valid & (~full | pop) & ~flush;
    ovf_set = hw_valid & full & ~pop & ~flush;
    udf_set = data_rd & empty;

    head_ext = '0;
    head_ext[WW-1:0] = mem_q[rd_ptr_q];

    stat_word = {14'b0, udf_q, ovf_q, 6'b0, full, empty, 8'(count_q)};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_set | (ovf_q & ~ovf_clr);
    udf_d    = udf_set | (udf_q & ~udf_clr);
    rdata_d  = rdata_q;
    rvalid_d = data_rd | stat_rd;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    // The head word is returned even when a flush lands in the same cycle.
    if (data_rd)      rdata_d = empty ? 32'h0 : head_ext;
    else if (stat_rd) rdata_d = stat_word;
  end

  always_ff @(posedge io_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= hw_data;
  end

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign io_rdata  = rdata_q;
  assign io_rvalid = rvalid_q;
  assign io_irq    = (count_q != '0) | ovf_q;
endmodule

// File: tb/tb_bus_event_fifo.sv
// Directed bench for bus_event_fifo (_ADD=0, _BYTE=4, _DEPTH=8).
module tb_bus_event_fifo;
  logic        io_clk = 1'b0;
  logic        io_rst;
  logic        hw_valid;
  logic [31:0] hw_data;
  logic        io_ren;
  logic [3:0]  io_wen;
  logic [31:0] io_addr;
  logic [31:0] io_din;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        io_irq;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  bus_event_fifo #(._ADD(32'h0), ._BYTE(4), ._DEPTH(8)) dut (
    .io_clk(io_clk), .io_rst(io_rst), .hw_valid(hw_valid), .hw_data(hw_data),
    .io_ren(io_ren), .io_wen(io_wen), .io_addr(io_addr), .io_din(io_din),
    .io_rdata(io_rdata), .io_rvalid(io_rvalid), .io_irq(io_irq)
  );

  always #5 io_clk = ~io_clk;

  task automatic cyc();
    @(posedge io_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] d);
    hw_valid = 1'b1; hw_data = d;
    cyc();
    hw_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    io_ren = 1'b1; io_addr = a;
    cyc();
    io_ren = 1'b0;
  endtask

  task automatic stat_wr(input logic [3:0] wen, input logic [31:0] din);
    io_addr = 32'h4; io_wen = wen; io_din = din;
    cyc();
    io_wen = 4'b0;
  endtask

  task automatic chk_stat(input string tag, input logic [31:0] exp);
    rd(32'h4);
    chk({tag, "_rvalid"}, {31'b0, io_rvalid}, 32'h1);
    chk(tag, io_rdata, exp);
  endtask

  initial begin
    io_rst = 1'b1; hw_valid = 1'b0; hw_data = '0; io_ren = 1'b0;
    io_wen = '0; io_addr = '0; io_din = '0;
    cyc(); cyc();
    io_rst = 1'b0;
    chk("rst_rvalid", {31'b0, io_rvalid}, 32'h0);
    chk("rst_rdata", io_rdata, 32'h0);
    chk("rst_irq", {31'b0, io_irq}, 32'h0);
    chk_stat("stat_reset", 32'h0000_0100);
    cyc();
    chk("rvalid_one_cycle", {31'b0, io_rvalid}, 32'h0);

    // Three pushes, then back-to-back DATA reads.
    push(32'h11); push(32'h22); push(32'h33);
    chk("irq_nonempty", {31'b0, io_irq}, 32'h1);
    io_ren = 1'b1; io_addr = 32'h0;
    cyc(); chk("pop_11", io_rdata, 32'h11);
    cyc(); chk("pop_22", io_rdata, 32'h22);
    cyc(); chk("pop_33", io_rdata, 32'h33);
    chk("pop_33_rvalid", {31'b0, io_rvalid}, 32'h1);
    io_ren = 1'b0;
    chk_stat("stat_drained", 32'h0000_0100);
    chk("irq_drained", {31'b0, io_irq}, 32'h0);

    // Overflow: nine pushes into eight entries, then W1C ovf.
    for (int i = 1; i <= 9; i++) push(32'(i));
    chk_stat("stat_ovf", 32'h0001_0208);
    stat_wr(4'b0100, 32'h0001_0000);
    chk("irq_after_ovf_clr", {31'b0, io_irq}, 32'h1);
    chk_stat("stat_ovf_clr", 32'h0000_0208);
    rd(32'h0);
    chk("pop_first_after_ovf", io_rdata, 32'h1);
    stat_wr(4'b1000, 32'h8000_0000);
    chk_stat("stat_flushed", 32'h0000_0100);

    // Non-hit read: no response, data held.
    rd(32'h40);
    chk("miss_rvalid", {31'b0, io_rvalid}, 32'h0);
    chk("miss_rdata", io_rdata, 32'h0000_0100);

    // Underflow, then push + read on an empty FIFO (no bypass).
    rd(32'h0);
    chk("udf_rdata", io_rdata, 32'h0);
    chk("udf_rvalid", {31'b0, io_rvalid}, 32'h1);
    chk_stat("stat_udf", 32'h0002_0100);
    stat_wr(4'b0100, 32'h0002_0000);
    chk_stat("stat_udf_clr", 32'h0000_0100);
    hw_valid = 1'b1; hw_data = 32'hAB; io_ren = 1'b1; io_addr = 32'h0;
    cyc();
    hw_valid = 1'b0; io_ren = 1'b0;
    chk("push_rd_empty_rdata", io_rdata, 32'h0);
    chk_stat("stat_push_rd_empty", 32'h0002_0001);
    rd(32'h0);
    chk("pop_ab", io_rdata, 32'hAB);
    stat_wr(4'b0100, 32'h0002_0000);

    // Flush in the same cycle as a push: flush wins, no ovf.
    for (int i = 0; i < 5; i++) push(32'h50 + 32'(i));
    hw_valid = 1'b1; hw_data = 32'h99;
    io_addr = 32'h4; io_wen = 4'b1000; io_din = 32'h8000_0000;
    cyc();
    hw_valid = 1'b0; io_wen = 4'b0;
    chk("irq_after_flush", {31'b0, io_irq}, 32'h0);
    chk_stat("stat_push_flush", 32'h0000_0100);

    // Full FIFO with simultaneous push + pop for 20 cycles: pointers wrap.
    for (int i = 0; i < 8; i++) begin
      push(32'hA0 + 32'(i));
      exp_q.push_back(32'hA0 + 32'(i));
    end
    for (int i = 0; i < 20; i++) begin
      logic [31:0] e;
      hw_valid = 1'b1; hw_data = 32'hB0 + 32'(i);
      io_ren = 1'b1; io_addr = 32'h0;
      cyc();
      e = exp_q.pop_front();
      exp_q.push_back(32'hB0 + 32'(i));
      chk($sformatf("wrap_%0d", i), io_rdata, e);
    end
    hw_valid = 1'b0; io_ren = 1'b0;
    chk_stat("stat_wrap_full", 32'h0000_0208);
    for (int i = 0; i < 8; i++) begin
      rd(32'h0);
      chk($sformatf("drain_%0d", i), io_rdata, exp_q.pop_front());
    end
    chk_stat("stat_after_drain", 32'h0000_0100);

    // Reset mid-operation with a read in flight.
    push(32'h77); push(32'h78);
    io_ren = 1'b1; io_addr = 32'h0; io_rst = 1'b1;
    cyc();
    io_ren = 1'b0; io_rst = 1'b0;
    chk("midrst_rvalid", {31'b0, io_rvalid}, 32'h0);
    chk("midrst_rdata", io_rdata, 32'h0);
    chk("midrst_irq", {31'b0, io_irq}, 32'h0);
    chk_stat("stat_midrst", 32'h0000_0100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bus_event_fifo.md
# bus_event_fifo

CPU-facing read-back mailbox: hardware logic pushes event words into a FIFO, and the CPU pops them over the same word-addressed store bus used by the write-capture registers (io_addr/io_wen/io_din). It is the reverse direction of those registers: hardware-to-CPU instead of CPU-to-hardware. Adds a read strobe and a registered read-data return path. A status word gives fill level, sticky error flags, flush control and an interrupt request.

## Interface
- _ADD, 32'h0: base address, 8-byte aligned; DATA at _ADD, STAT at _ADD+4
- _BYTE, 4: event word width in bytes (1..4); words are zero-extended to 32 bits on read
- _DEPTH, 8: FIFO entries; power of two, 2..128

- io_clk  in  1  sole clock, all logic on posedge
- io_rst  in  1  synchronous, active-high reset
- hw_valid  in  1  one-cycle push strobe from hardware
- hw_data  in  _BYTE*8  event word, sampled when hw_valid=1
- io_ren  in  1  CPU read strobe, qualified by io_addr
- io_wen  in  4  CPU byte write enables, qualified by io_addr
- io_addr  in  32  CPU byte address
- io_din  in  32  CPU write data
- io_rdata  out  32  read return data, registered
- io_rvalid  out  1  one-cycle pulse: io_rdata holds a new response
- io_irq  out  1  level interrupt: FIFO not empty or ovf set

## Operation
- Decode: hit = io_addr[31:3]==_ADD[31:3]. DATA selected when io_addr[2]=0, STAT when io_addr[2]=1.
- Push: hw_valid=1 and not full → store hw_data at the write pointer, then advance the pointer.
- Push while full → word dropped, ovf set. hw has no backpressure.
- DATA read (io_ren, hit, DATA selected):
  - Not empty → io_rdata = head word zero-extended; pop.
  - Empty → io_rdata = 0; udf set; no pop.
- STAT read layout:
  - [7:0] count
  - [8] empty
  - [9] full
  - [16] ovf
  - [17] udf
  - all other bits 0
- STAT write (hit, STAT selected):
  - io_wen[2]=1 with io_din[16]=1 → clear ovf.
  - io_wen[2]=1 with io_din[17]=1 → clear udf (write-1-to-clear).
  - io_wen[3]=1 with io_din[31]=1 → flush: pointers and count go to 0. Flags are unaffected.
- Writes to DATA are ignored.
- Pointers are log2(_DEPTH) bits and wrap modulo _DEPTH. count is log2(_DEPTH)+1 bits, range 0.._DEPTH.
- io_irq = (count!=0) | ovf, decoded from registered state.
- Simultaneous events:
  - Push + pop, not full, not empty → both happen; count unchanged.
  - Push + pop while full → both happen; no ovf.
  - Push + DATA read while empty → read returns 0, udf set, pushed word stored. No bypass.
  - Push + flush → flush wins; word dropped; ovf not set.
  - Pop + flush → read still returns the head word; FIFO ends empty.
  - Flag set + W1C clear in the same cycle → set wins.
  - io_ren and io_wen in the same cycle → both act independently.
- Reset:
  - Clears pointers, count, ovf, udf; io_rdata=0, io_rvalid=0, io_irq=0.
  - FIFO storage contents are don't-care.
  - Reset mid-operation discards all queued words and any pending response.

## Timing
- Read latency is 1 cycle: io_ren at edge N → io_rvalid=1 and io_rdata valid after edge N+1, for one cycle.
- io_rdata holds its value until the next response.
- A read with no address hit gives no io_rvalid and leaves io_rdata unchanged.
- Back-to-back reads on consecutive cycles are supported: one response per cycle, in order.
- Push at edge N updates count/empty/full/io_irq after edge N. A DATA read issued in cycle N+1 returns that word.
- Flags and flush take effect one edge after the qualifying strobe.
- No combinational path from any input to any output.

## Test plan
- Reset, then read STAT → io_rdata=32'h0000_0100 (empty=1), io_irq=0.
- Push 0x11, 0x22, 0x33, then three DATA reads → responses 0x11, 0x22, 0x33. After the third read, STAT=0x100 and io_irq=0.
- _DEPTH=8: push 9 words → STAT=0x0001_0208 (count 8, full, ovf). Write 0x0001_0000 with io_wen=4'b0100 → ovf clears, io_irq stays 1.
- DATA read while empty → io_rdata=0, STAT bit17=1. Then push and DATA read in the same cycle on an empty FIFO → response 0, count=1.
- Fill 5 words, flush (io_wen=4'b1000, io_din=32'h8000_0000) in the same cycle as a push → count=0, ovf=0.
- Full FIFO, push + pop in the same cycle, repeated for 20 cycles → pointer wrap. Responses stay in push order, count stays 8, ovf stays 0.
